sobel_frame_ctrl: RTL and testbench

- Frame-level controller for the HLS Sobel accelerator (ap_ctrl_hs, 128-bit AXI-stream, 16 px/beat).
- Accepts a per-frame request carrying rows/cols and drives the accelerator's rows/cols/ap_start.
- Gates the upstream pixel stream to exactly one frame of beats, and counts beats on both gradient output streams.
- Reports per-frame done/error to the host-side sequencer.

---
 rtl/sobel_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//   Frame-level controller for the HLS Sobel accelerator (ap_ctrl_hs
//   handshake, 128-bit AXI-stream, PIX_CYCLE pixels per beat).
//   It validates a per-frame rows/cols request, drives the accelerator's
//   rows/cols/ap_start, and gates the upstream stream so that exactly
//   one frame of beats is passed. It counts beats on both gradient
//   outputs and reports done/error per frame.
//
// Optional feature macro: SOBEL_CTRL_WDOG_EN
//   When defined, a stall watchdog aborts a frame after WDOG_CYCLES-1
//   cycles without progress and pulses wdog_to. When undefined, there is
//   no counter and wdog_to is tied to 0.
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   cfg_rows, cfg_cols      frame geometry offered with frame_req
//   frame_req               level request, sampled only in IDLE
//   frame_ack/done/err      1-cycle status pulses to the host sequencer
//   wdog_to                 1-cycle pulse with frame_done on a watchdog abort
//   busy                    high whenever the FSM is not in IDLE
//   s_t*                    upstream pixel stream (slave side)
//   acc_rows/cols/ap_*      accelerator control (ap_ctrl_hs)
//   acc_in_t*               accelerator input stream (master side)
//   acc_o1_t*, acc_o2_t*    monitored handshakes of the two output streams
//   o1_beats, o2_beats      output beat counts of the current or last frame
//   dbg_state               current FSM state (0 IDLE, 1 START, 2 RUN, 3 DONE)
//
// Handshake rule for every stream here: a beat transfers on a rising
// clock edge where tvalid and tready are both high. A source never
// withdraws a beat based on tready, and this block's tvalid never
// depends on its own tready.

module sobel_frame_ctrl #(
  parameter int PIX_CYCLE   = 16,
  parameter int DW          = 128,
  parameter int CNT_W       = 24,
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [31:0]       cfg_rows,
  input  logic [31:0]       cfg_cols,
  input  logic              frame_req,
  output logic              frame_ack,
  output logic              frame_done,
  output logic              frame_err,
  output logic              wdog_to,
  output logic              busy,
  input  logic [DW-1:0]     s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [31:0]       acc_rows,
  output logic [31:0]       acc_cols,
  output logic              acc_ap_start,
  input  logic              acc_ap_ready,
  input  logic              acc_ap_done,
  output logic [DW-1:0]     acc_in_tdata,
  output logic              acc_in_tvalid,
  input  logic              acc_in_tready,
  input  logic              acc_o1_tvalid,
  input  logic              acc_o1_tready,
  input  logic              acc_o2_tvalid,
  input  logic              acc_o2_tready,
  output logic [CNT_W-1:0]  o1_beats,
  output logic [CNT_W-1:0]  o2_beats,
  output logic [1:0]        dbg_state
);

  // Elaboration-time parameter sanity (the watchdog compares against
  // WDOG_CYCLES-1, and the beat math divides by PIX_CYCLE).
  if (WDOG_CYCLES < 2 || PIX_CYCLE < 1 || CNT_W > 63) begin : g_param_check
    $error("sobel_frame_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      rows_q, rows_d;
  logic [31:0]      cols_q, cols_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] in_rem_q, in_rem_d;
  logic [CNT_W-1:0] o1_q, o1_d;
  logic [CNT_W-1:0] o2_q, o2_d;
  logic             done_seen_q, done_seen_d;
  logic             early_q, early_d;
  logic             ack_q, ack_d;
  logic             cfg_err_q, cfg_err_d;

  // Request decode: beats = rows * (cols / PIX_CYCLE), computed at full
  // width so the range check sees any overflow past CNT_W.
  logic [31:0] cols_div;
  logic [63:0] beats_full;
  logic        cfg_ok;

  always_comb begin
    cols_div   = cfg_cols / 32'(PIX_CYCLE);
    beats_full = {32'd0, cfg_rows} * {32'd0, cols_div};
    cfg_ok     = (cfg_rows != 32'd0) && (cfg_cols != 32'd0) &&
                 ((cfg_cols % 32'(PIX_CYCLE)) == 32'd0) &&
                 ((beats_full >> CNT_W) == 64'd0);
  end

  logic active;
  logic rem_nz;
  logic in_hs;
  logic o1_hs;
  logic o2_hs;
  logic wdog_hit;
  logic wdog_flag;

  assign active = (state_q == S_START) || (state_q == S_RUN);
  assign rem_nz = (in_rem_q != '0);
  assign in_hs  = acc_in_tvalid & acc_in_tready;
  assign o1_hs  = active & acc_o1_tvalid & acc_o1_tready;
  assign o2_hs  = active & acc_o2_tvalid & acc_o2_tready;

`ifdef SOBEL_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

  logic [WDOG_W-1:0] stall_q, stall_d;
  logic              wdog_q, wdog_d;

  // Any sign of forward progress restarts the stall window.
  always_comb begin
    stall_d = '0;
    if (active && !(acc_ap_ready || in_hs || o1_hs || o2_hs)) begin
      stall_d = stall_q + WDOG_W'(1);
    end
    wdog_d = wdog_q;
    if (state_q == S_IDLE && frame_req && cfg_ok) begin
      wdog_d = 1'b0;
    end else if (wdog_hit) begin
      wdog_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q <= '0;
      wdog_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      wdog_q  <= wdog_d;
    end
  end

  assign wdog_hit  = active && (stall_q == WDOG_W'(WDOG_CYCLES - 1));
  assign wdog_flag = wdog_q;
`else
  assign wdog_hit  = 1'b0;
  assign wdog_flag = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. An accelerator done that arrives while input beats
  // are still owed ends the frame at once (flagged as an error later).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_req && cfg_ok) state_d = S_START;
      end
      S_START: begin
        if (wdog_hit)                    state_d = S_DONE;
        else if (acc_ap_done && rem_nz)  state_d = S_DONE;
        else if (acc_ap_ready)           state_d = S_RUN;
      end
      S_RUN: begin
        if (wdog_hit)                    state_d = S_DONE;
        else if (acc_ap_done && rem_nz)  state_d = S_DONE;
        else if ((done_seen_q || acc_ap_done) && !rem_nz) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. ack_q is high only in the first START cycle, which
  // holds ap_start off for that cycle.
  always_comb begin
    busy          = (state_q != S_IDLE);
    acc_ap_start  = (state_q == S_START) && !ack_q && !wdog_hit;
    acc_in_tdata  = s_tdata;
    acc_in_tvalid = active && s_tvalid && rem_nz && !wdog_hit;
    s_tready      = active && acc_in_tready && rem_nz && !wdog_hit;
    frame_ack     = ack_q;
    frame_done    = (state_q == S_DONE);
    frame_err     = cfg_err_q ||
                    ((state_q == S_DONE) &&
                     ((o1_q != exp_q) || (o2_q != exp_q) || early_q || wdog_flag));
    wdog_to       = (state_q == S_DONE) && wdog_flag;
    acc_rows      = rows_q;
    acc_cols      = cols_q;
    o1_beats      = o1_q;
    o2_beats      = o2_q;
    dbg_state     = state_q;
  end

  // Datapath next state
  always_comb begin
    rows_d      = rows_q;
    cols_d      = cols_q;
    exp_d       = exp_q;
    in_rem_d    = in_rem_q;
    o1_d        = o1_q;
    o2_d        = o2_q;
    done_seen_d = done_seen_q;
    early_d     = early_q;
    ack_d       = 1'b0;
    cfg_err_d   = 1'b0;

    if (state_q == S_IDLE && frame_req) begin
      if (cfg_ok) begin
        rows_d      = cfg_rows;
        cols_d      = cfg_cols;
        exp_d       = beats_full[CNT_W-1:0];
        in_rem_d    = beats_full[CNT_W-1:0];
        o1_d        = '0;
        o2_d        = '0;
        done_seen_d = 1'b0;
        early_d     = 1'b0;
        ack_d       = 1'b1;
      end else begin
        cfg_err_d   = 1'b1;
      end
    end

    if (active) begin
      if (in_hs && rem_nz)           in_rem_d    = in_rem_q - CNT_W'(1);
      if (o1_hs && (o1_q != '1))     o1_d        = o1_q + CNT_W'(1);
      if (o2_hs && (o2_q != '1))     o2_d        = o2_q + CNT_W'(1);
      if (acc_ap_done)               done_seen_d = 1'b1;
      if (acc_ap_done && rem_nz)     early_d     = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rows_q      <= '0;
      cols_q      <= '0;
      exp_q       <= '0;
      in_rem_q    <= '0;
      o1_q        <= '0;
      o2_q        <= '0;
      done_seen_q <= 1'b0;
      early_q     <= 1'b0;
      ack_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      exp_q       <= exp_d;
      in_rem_q    <= in_rem_d;
      o1_q        <= o1_d;
      o2_q        <= o2_d;
      done_seen_q <= done_seen_d;
      early_q     <= early_d;
      ack_q       <= ack_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

  localparam int DW    = 128;
  localparam int CNT_W = 24;

  // clock / reset
  logic ap_clk;
  logic ap_rst_n;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  logic [31:0]      cfg_rows, cfg_cols;
  logic             frame_req, frame_ack, frame_done, frame_err, wdog_to, busy;
  logic [DW-1:0]    s_tdata;
  logic             s_tvalid, s_tready;
  logic [31:0]      acc_rows, acc_cols;
  logic             acc_ap_start, acc_ap_ready, acc_ap_done;
  logic [DW-1:0]    acc_in_tdata;
  logic             acc_in_tvalid, acc_in_tready;
  logic             acc_o1_tvalid, acc_o1_tready, acc_o2_tvalid, acc_o2_tready;
  logic [CNT_W-1:0] o1_beats, o2_beats;
  logic [1:0]       dbg_state;

  sobel_frame_ctrl #(.PIX_CYCLE(16), .DW(DW), .CNT_W(CNT_W), .WDOG_CYCLES(64)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .frame_req(frame_req), .frame_ack(frame_ack), .frame_done(frame_done),
    .frame_err(frame_err), .wdog_to(wdog_to), .busy(busy),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .acc_rows(acc_rows), .acc_cols(acc_cols),
    .acc_ap_start(acc_ap_start), .acc_ap_ready(acc_ap_ready), .acc_ap_done(acc_ap_done),
    .acc_in_tdata(acc_in_tdata), .acc_in_tvalid(acc_in_tvalid), .acc_in_tready(acc_in_tready),
    .acc_o1_tvalid(acc_o1_tvalid), .acc_o1_tready(acc_o1_tready),
    .acc_o2_tvalid(acc_o2_tvalid), .acc_o2_tready(acc_o2_tready),
    .o1_beats(o1_beats), .o2_beats(o2_beats), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit in_stall = 1'b0;

  // results of the last run_frame
  int r_ack_cnt, r_ack_cyc, r_first_start, r_start_cnt, r_in_beats;
  int r_done_cyc, r_early_cyc;
  bit r_stall_seen, r_err, r_wdog, r_wdog_any, r_busy_after;
  bit r_ack_after_done, r_tready_after, r_tdata_bad;
  logic [CNT_W-1:0] r_o1, r_o2;

  task automatic idle_inputs();
    frame_req     = 1'b0;
    s_tvalid      = 1'b0;
    s_tdata       = '0;
    acc_ap_ready  = 1'b0;
    acc_ap_done   = 1'b0;
    acc_in_tready = 1'b0;
    acc_o1_tvalid = 1'b0;
    acc_o1_tready = 1'b0;
    acc_o2_tvalid = 1'b0;
    acc_o2_tready = 1'b0;
  endtask

  // Driver plus accelerator model for one frame. ap_ready follows the
  // third ap_start cycle; outputs emit n1/n2 beats once input has begun;
  // ap_done follows completion, or after early_after input beats.
  task automatic run_frame(input logic [31:0] rows, input logic [31:0] cols,
                           input int n1, input int n2, input int early_after,
                           input bit hold_req);
    int exp_beats, start_cnt, o1s, o2s;
    bit done_given, got_ack, got_done, fin;
    exp_beats = int'(rows) * (int'(cols) / 16);
    start_cnt = 0; o1s = 0; o2s = 0;
    done_given = 0; got_ack = 0; got_done = 0; fin = 0;
    r_ack_cnt = 0; r_ack_cyc = -1; r_first_start = -1; r_in_beats = 0;
    r_done_cyc = -1; r_early_cyc = -1; r_stall_seen = 0; r_err = 0;
    r_wdog = 0; r_wdog_any = 0; r_busy_after = 1; r_ack_after_done = 0;
    r_tready_after = 0; r_tdata_bad = 0; r_o1 = '0; r_o2 = '0;
    cfg_rows = rows; cfg_cols = cols; frame_req = 1'b1;
    s_tvalid = 1'b1; acc_in_tready = !in_stall;
    acc_o1_tready = 1'b1; acc_o2_tready = 1'b1;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge ap_clk);
      if (frame_ack) begin
        r_ack_cnt++;
        if (r_ack_cyc < 0) r_ack_cyc = cyc;
        if (got_done) r_ack_after_done = 1;
        got_ack = 1;
        if (!hold_req) frame_req = 1'b0;
      end
      if (acc_ap_start) begin
        start_cnt++;
        if (r_first_start < 0) r_first_start = cyc;
      end
      if (wdog_to) r_wdog_any = 1;
      if (got_done) begin
        r_busy_after = busy;
        fin = 1;
      end
      if (frame_done && !got_done) begin
        got_done = 1; r_done_cyc = cyc; r_err = frame_err;
        r_o1 = o1_beats; r_o2 = o2_beats; r_wdog = wdog_to;
      end
      acc_ap_ready = acc_ap_start && (start_cnt == 3);
      acc_ap_done  = 1'b0;
      if (!done_given && got_ack && !got_done) begin
        if (early_after >= 0) begin
          if (r_in_beats >= early_after) begin
            acc_ap_done = 1'b1; done_given = 1; r_early_cyc = cyc;
          end
        end else if (r_in_beats == exp_beats && o1s >= n1 && o2s >= n2) begin
          acc_ap_done = 1'b1; done_given = 1;
        end
      end
      acc_o1_tvalid = (r_in_beats > 0) && (o1s < n1) && !got_done;
      acc_o2_tvalid = (r_in_beats > 0) && (o2s < n2) && !got_done;
      acc_in_tready = !in_stall;
      s_tdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (acc_in_tdata !== s_tdata) r_tdata_bad = 1;
      if (s_tvalid && s_tready) r_in_beats++;
      if (busy && !got_done && r_in_beats == exp_beats && acc_in_tready && !s_tready)
        r_stall_seen = 1;
      if (got_done && s_tready) r_tready_after = 1;
      if (busy && !got_done && acc_o1_tvalid && acc_o1_tready) o1s++;
      if (busy && !got_done && acc_o2_tvalid && acc_o2_tready) o2s++;
    end
    r_start_cnt = start_cnt;
    if (!hold_req) frame_req = 1'b0;
    s_tvalid = 1'b0; acc_ap_ready = 1'b0; acc_ap_done = 1'b0;
    acc_o1_tvalid = 1'b0; acc_o2_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cfg_rows = '0; cfg_cols = '0;
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    #1;
    checks++; if (frame_ack !== 1'b0)  begin errors++; $display("FAIL reset_ack got %b want 0", frame_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
    checks++; if (wdog_to !== 1'b0)    begin errors++; $display("FAIL reset_wdog got %b want 0", wdog_to); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (acc_ap_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", acc_ap_start); end
    checks++; if (acc_rows !== 32'd0 || acc_cols !== 32'd0)
      begin errors++; $display("FAIL reset_rowcol got %0d/%0d want 0/0", acc_rows, acc_cols); end
    checks++; if (o1_beats !== '0 || o2_beats !== '0)
      begin errors++; $display("FAIL reset_beats got %0d/%0d want 0/0", o1_beats, o2_beats); end
    checks++; if (dbg_state !== 2'd0)  begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    s_tvalid = 1'b1; acc_in_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0 || acc_in_tvalid !== 1'b0)
      begin errors++; $display("FAIL idle_gate got tready=%b tvalid=%b want 0/0", s_tready, acc_in_tvalid); end
    s_tvalid = 1'b0; acc_in_tready = 1'b0;
  endtask

  task automatic test_normal();
    run_frame(32'd128, 32'd128, 1024, 1024, -1, 1'b0);
    checks++; if (r_done_cyc < 0) begin errors++; $display("FAIL normal_timeout got no frame_done want frame_done"); end
    checks++; if (r_ack_cnt != 1) begin errors++; $display("FAIL normal_ack_cnt got %0d want 1", r_ack_cnt); end
    checks++; if (r_first_start - r_ack_cyc != 1)
      begin errors++; $display("FAIL normal_ack_to_start got %0d want 1", r_first_start - r_ack_cyc); end
    checks++; if (r_start_cnt != 3) begin errors++; $display("FAIL normal_start_cycles got %0d want 3", r_start_cnt); end
    checks++; if (r_in_beats != 1024) begin errors++; $display("FAIL normal_in_beats got %0d want 1024", r_in_beats); end
    checks++; if (!r_stall_seen) begin errors++; $display("FAIL normal_stall_1025 got passed want stalled"); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL normal_err got %b want 0", r_err); end
    checks++; if (r_o1 !== 24'd1024 || r_o2 !== 24'd1024)
      begin errors++; $display("FAIL normal_out_beats got %0d/%0d want 1024/1024", r_o1, r_o2); end
    checks++; if (acc_rows !== 32'd128 || acc_cols !== 32'd128)
      begin errors++; $display("FAIL normal_rowcol got %0d/%0d want 128/128", acc_rows, acc_cols); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL normal_busy_after got %b want 0", r_busy_after); end
    checks++; if (r_wdog_any) begin errors++; $display("FAIL normal_wdog got 1 want 0"); end
    checks++; if (r_tdata_bad) begin errors++; $display("FAIL normal_tdata got differing want passthrough"); end
  endtask

  task automatic test_bad_cfg(input logic [31:0] rows, input logic [31:0] cols);
    cfg_rows = rows; cfg_cols = cols; frame_req = 1'b1;
    @(negedge ap_clk);
    checks++; if (frame_err !== 1'b1 || frame_ack !== 1'b0)
      begin errors++; $display("FAIL badcfg_%0dx%0d got err=%b ack=%b want 1/0", rows, cols, frame_err, frame_ack); end
    frame_req = 1'b0;
    @(negedge ap_clk);
    checks++; if (busy !== 1'b0 || frame_ack !== 1'b0 || frame_err !== 1'b0)
      begin errors++; $display("FAIL badcfg_after_%0dx%0d got busy=%b ack=%b err=%b want 0/0/0", rows, cols, busy, frame_ack, frame_err); end
    checks++; if (acc_cols !== 32'd128 || acc_rows !== 32'd128)
      begin errors++; $display("FAIL badcfg_keep_%0dx%0d got %0d/%0d want 128/128", rows, cols, acc_rows, acc_cols); end
  endtask

  task automatic test_o2_short();
    run_frame(32'd128, 32'd128, 1024, 1023, -1, 1'b0);
    checks++; if (r_done_cyc < 0 || r_err !== 1'b1)
      begin errors++; $display("FAIL o2short_done_err got done_cyc=%0d err=%b want done with err=1", r_done_cyc, r_err); end
    checks++; if (r_o2 !== 24'd1023 || r_o1 !== 24'd1024)
      begin errors++; $display("FAIL o2short_beats got %0d/%0d want 1024/1023", r_o1, r_o2); end
  endtask

  task automatic test_early_done();
    run_frame(32'd128, 32'd128, 0, 0, 500, 1'b0);
    checks++; if (r_early_cyc < 0 || r_done_cyc != r_early_cyc + 1)
      begin errors++; $display("FAIL early_latency got done_cyc=%0d want %0d", r_done_cyc, r_early_cyc + 1); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL early_err got %b want 1", r_err); end
    checks++; if (r_tready_after) begin errors++; $display("FAIL early_tready_after got 1 want 0"); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL early_busy_after got %b want 0", r_busy_after); end
  endtask

  task automatic test_back_to_back();
    run_frame(32'd1, 32'd16, 1, 1, -1, 1'b1);
    checks++; if (r_done_cyc < 0 || r_ack_cnt != 1 || r_ack_after_done)
      begin errors++; $display("FAIL b2b_first got done_cyc=%0d acks=%0d late_ack=%b want done/1/0", r_done_cyc, r_ack_cnt, r_ack_after_done); end
    checks++; if (r_err !== 1'b0 || r_o1 !== 24'd1)
      begin errors++; $display("FAIL b2b_first_result got err=%b o1=%0d want 0/1", r_err, r_o1); end
    run_frame(32'd1, 32'd16, 1, 1, -1, 1'b0);
    checks++; if (r_ack_cyc != 0 || r_ack_cnt != 1)
      begin errors++; $display("FAIL b2b_second_ack got cyc=%0d cnt=%0d want 0/1", r_ack_cyc, r_ack_cnt); end
    checks++; if (r_done_cyc < 0 || r_err !== 1'b0)
      begin errors++; $display("FAIL b2b_second_done got done_cyc=%0d err=%b want done/0", r_done_cyc, r_err); end
  endtask

`ifdef SOBEL_CTRL_WDOG_EN
  task automatic test_watchdog();
    in_stall = 1'b1;
    run_frame(32'd128, 32'd128, 0, 0, -1, 1'b0);
    in_stall = 1'b0;
    checks++; if (r_done_cyc < 0 || r_done_cyc > 200)
      begin errors++; $display("FAIL wdog_done got done_cyc=%0d want 64..200", r_done_cyc); end
    checks++; if (r_err !== 1'b1 || r_wdog !== 1'b1)
      begin errors++; $display("FAIL wdog_flags got err=%b wdog=%b want 1/1", r_err, r_wdog); end
    checks++; if (r_busy_after !== 1'b0 || r_in_beats != 0)
      begin errors++; $display("FAIL wdog_after got busy=%b beats=%0d want 0/0", r_busy_after, r_in_beats); end
  endtask
`endif

  task automatic test_reset_mid_run();
    bit got = 0;
    cfg_rows = 32'd65535; cfg_cols = 32'd4096; frame_req = 1'b1;
    s_tvalid = 1'b1; acc_in_tready = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge ap_clk);
      if (frame_ack) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL maxcfg_ack got none want ack"); end
    frame_req = 1'b0;
    @(negedge ap_clk);
    checks++; if (acc_ap_start !== 1'b1 || acc_rows !== 32'd65535)
      begin errors++; $display("FAIL maxcfg_start got start=%b rows=%0d want 1/65535", acc_ap_start, acc_rows); end
    acc_ap_ready = 1'b1;
    @(negedge ap_clk);
    acc_ap_ready = 1'b0;
    acc_o1_tvalid = 1'b1; acc_o1_tready = 1'b1;
    repeat (5) @(negedge ap_clk);
    acc_o1_tvalid = 1'b0;
    checks++; if (dbg_state !== 2'd2 || o1_beats !== 24'd5)
      begin errors++; $display("FAIL midrun_state got state=%0d o1=%0d want 2/5", dbg_state, o1_beats); end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || s_tready !== 1'b0 || acc_in_tvalid !== 1'b0 || acc_ap_start !== 1'b0)
      begin errors++; $display("FAIL async_reset_ctrl got busy=%b tready=%b tvalid=%b start=%b want 0", busy, s_tready, acc_in_tvalid, acc_ap_start); end
    checks++; if (dbg_state !== 2'd0 || o1_beats !== '0 || acc_rows !== 32'd0)
      begin errors++; $display("FAIL async_reset_regs got state=%0d o1=%0d rows=%0d want 0", dbg_state, o1_beats, acc_rows); end
    idle_inputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_cfg(32'd128, 32'd120);
    test_bad_cfg(32'd0, 32'd128);
    test_bad_cfg(32'd65536, 32'd4096);
    test_o2_short();
    test_early_done();
    test_back_to_back();
`ifdef SOBEL_CTRL_WDOG_EN
    test_watchdog();
`endif
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
